// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave RAM with programmable wait states, byte-lane writes and a side-load port.
// Define AVALON_RANDOM_WAIT_EN to draw each transaction's wait count from a 16-bit LFSR.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; waitrequest follows read|write
// ST_WAIT | request latched, counting wait states, watching for abort
// ST_ACK  | single cycle with waitrequest low; write lanes commit here
module avalon_mem_responder #(
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    input  logic [3:0]           byteenable,
    output logic                 waitrequest,
    output logic [31:0]          readdata,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    output logic                 bus_err
);

    localparam int DEPTH = 2**ADDR_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t               state;
    logic [31:0]          mem [DEPTH];
    logic [29:0]          word_off;
    logic [ADDR_BITS-1:0] index;
    logic                 addr_ok;
    logic                 req_held;
    logic [31:0]          req_addr;
    logic [31:0]          req_data;
    logic [3:0]           req_be;
    logic                 req_write;
    logic                 req_ok;
    logic [ADDR_BITS-1:0] req_index;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_load;

    // BASE_ADDR is word aligned, so subtracting the word parts equals (address-BASE_ADDR)>>2
    assign word_off = address[31:2] - BASE_ADDR[31:2];
    assign index    = word_off[ADDR_BITS-1:0];
    assign addr_ok  = (address[1:0] == 2'b00) && ((word_off >> ADDR_BITS) == 30'd0);

    assign req_held = (req_write ? (write && !read) : (read && !write)) && (address == req_addr);

    assign waitrequest = reset || (state == ST_WAIT) || ((state == ST_IDLE) && (read || write));

`ifdef AVALON_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign wait_load = 4'(32'(lfsr[3:0]) % (WAIT_CYCLES + 1));
`else
    assign wait_load = 4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            readdata  <= '0;
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
            req_ok    <= 1'b0;
            req_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read && write) begin
                        state     <= ST_ACK;
                        readdata  <= '0;
                        bus_err   <= 1'b1;
                        req_write <= 1'b0;
                        req_ok    <= 1'b0;
                    end else if (read || write) begin
                        state     <= ST_WAIT;
                        wait_cnt  <= wait_load;
                        req_addr  <= address;
                        req_data  <= writedata;
                        req_be    <= byteenable;
                        req_write <= write;
                        req_ok    <= addr_ok;
                        req_index <= index;
                        if (!addr_ok) bus_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!req_held) begin
                        state   <= ST_IDLE;
                        bus_err <= 1'b1;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_ACK;
                        if (!req_write) readdata <= req_ok ? mem[req_index] : '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Side-load is issued last so it overrides an ACK write to the same word
    always_ff @(posedge clk) begin
        if (!reset && (state == ST_ACK) && req_write && req_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) mem[req_index][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
        if (load_en) mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Self-checking bench for avalon_mem_responder: directed vector table, hand-written
// corner sequences, then random transactions against a word-array reference model.
module tb_avalon_mem_responder;

    localparam int          ADDR_BITS = 8;
    localparam int          WAIT_CYC  = 2;
    localparam logic [31:0] BASE      = 32'hBFC00000;
    localparam int          LAT       = 2 + WAIT_CYC;
    localparam int          DEPTH     = 2**ADDR_BITS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:0]          address;
    logic                 read;
    logic                 write;
    logic [31:0]          writedata;
    logic [3:0]           byteenable;
    logic                 waitrequest;
    logic [31:0]          readdata;
    logic                 load_en;
    logic [ADDR_BITS-1:0] load_addr;
    logic [31:0]          load_data;
    logic                 bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    avalon_mem_responder #(
        .ADDR_BITS  (ADDR_BITS),
        .WAIT_CYCLES(WAIT_CYC),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    vec_t vecs[11];

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd;
    bit          m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = ADDR_BITS'(a); load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // One bus transaction; lat counts cycles from request to the cycle with waitrequest low.
    // load_at >= 0 asserts the side-load strobe during that cycle of the transaction.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int load_at, input int l_addr,
                        input logic [31:0] l_data, output logic [31:0] rdata, output int lat);
        bit got = 0;
        @(posedge clk); #1;
        read = rd; write = wr; address = a; writedata = d; byteenable = be;
        lat = 0;
        rdata = 'x;
        load_addr = ADDR_BITS'(l_addr); load_data = l_data;
        load_en = (load_at == 0);
        while (lat < 40 && !got) begin
            #1;
            if (!waitrequest) begin
                got = 1;
                rdata = readdata;
            end else begin
                @(posedge clk); #1;
                lat++;
                load_en = (lat == load_at);
            end
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; load_en = 1'b0;
    endtask

    initial begin
        logic [31:0] rdata;
        int          lat;

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        byteenable = '0; load_en = 1'b0; load_addr = '0; load_data = '0;

        // Preload while the master is still held in reset
        load(1,   32'h24020200);
        load(5,   32'h11223344);
        load(255, 32'hCAFEF00D);
        load(3,   32'hAAAAAAAA);
        load(7,   32'h01010101);
        load(9,   32'h12345678);
        #1 chk("wait_in_reset", {31'd0, waitrequest}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
        chk("idle_no_req_wait", {31'd0, waitrequest}, 32'd0);

        //              rst rd wr addr          wdata         be       chk rd            lat  err
        vecs[0]  = '{0, 1, 0, 32'hBFC00004, 32'h0,        4'h0, 1, 32'h24020200, LAT, 0};
        vecs[1]  = '{0, 0, 1, 32'hBFC00014, 32'hDEADBEEF, 4'h5, 1, 32'h24020200, LAT, 0};
        vecs[2]  = '{0, 1, 0, 32'hBFC00014, 32'h0,        4'h0, 1, 32'h11AD33EF, LAT, 0};
        vecs[3]  = '{0, 0, 1, 32'hBFC00014, 32'h0,        4'h0, 1, 32'h11AD33EF, LAT, 0};
        vecs[4]  = '{0, 1, 0, 32'hBFC00014, 32'h0,        4'h0, 1, 32'h11AD33EF, LAT, 0};
        vecs[5]  = '{0, 1, 0, 32'hBFC003FC, 32'h0,        4'h0, 1, 32'hCAFEF00D, LAT, 0};
        vecs[6]  = '{0, 1, 0, 32'hBFC00002, 32'h0,        4'h0, 1, 32'h0,        LAT, 1};
        vecs[7]  = '{1, 1, 1, 32'hBFC00004, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1,   1};
        vecs[8]  = '{1, 1, 0, 32'hBFC00004, 32'h0,        4'h0, 1, 32'h24020200, LAT, 0};
        vecs[9]  = '{0, 0, 1, 32'hBFC00400, 32'h0,        4'hF, 0, 32'h0,        LAT, 1};
        vecs[10] = '{0, 1, 0, 32'h00000000, 32'h0,        4'h0, 1, 32'h0,        LAT, 1};

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                #1 chk($sformatf("vec%0d_reset_err", i), {31'd0, bus_err}, 32'd0);
            end
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, -1, 0, 32'h0,
                 rdata, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_readdata", i), rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_bus_err", i), {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
        end

        // Read withdrawn during WAIT: abort, error, no data returned
        do_reset();
        @(posedge clk); #1;
        read = 1'b1; address = 32'hBFC00004;
        @(posedge clk); #2;
        chk("abort_in_wait", {31'd0, waitrequest}, 32'd1);
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        chk("abort_bus_err", {31'd0, bus_err}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_no_ack_rd%0d", c), readdata, 32'h0);
        end

        // Side-load and ACK write hit word 3 in the same cycle: load wins
        do_reset();
        xfer(0, 1, 32'hBFC0000C, 32'h00000000, 4'hF, LAT, 3, 32'h55AA55AA, rdata, lat);
        chk("collide_wr_latency", lat, LAT);
        xfer(1, 0, 32'hBFC0000C, 32'h0, 4'h0, -1, 0, 32'h0, rdata, lat);
        chk("collide_word3", rdata, 32'h55AA55AA);

        // Side-load on the edge that registers read data: old word returned, new word stored
        xfer(1, 0, 32'hBFC0001C, 32'h0, 4'h0, LAT - 1, 7, 32'h02020202, rdata, lat);
        chk("load_vs_read_old", rdata, 32'h01010101);
        xfer(1, 0, 32'hBFC0001C, 32'h0, 4'h0, -1, 0, 32'h0, rdata, lat);
        chk("load_vs_read_new", rdata, 32'h02020202);

        // Reset during a pending write discards it
        @(posedge clk); #1;
        write = 1'b1; address = 32'hBFC00024; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        #1 chk("rst_mid_wait", {31'd0, waitrequest}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; write = 1'b0;
        #1;
        chk("rst_mid_readdata", readdata, 32'h0);
        chk("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
        xfer(1, 0, 32'hBFC00024, 32'h0, 4'h0, -1, 0, 32'h0, rdata, lat);
        chk("rst_mid_word9", rdata, 32'h12345678);

        // Random traffic against the reference model
        do_reset();
        m_err = 0;
        m_rd  = 32'h0;
        for (int w = 0; w < DEPTH; w++) begin
            m_mem[w] = $urandom();
            load(w, m_mem[w]);
        end
        for (int t = 0; t < 300; t++) begin
            int          op;
            bit          rd, wr, ok;
            logic [31:0] a, d, off;
            logic [3:0]  be;
            op = $urandom_range(0, 19);
            d  = $urandom();
            be = 4'($urandom_range(0, 15));
            if (op == 19) begin
                do_reset();
                m_err = 0;
                m_rd  = 32'h0;
                #1 chk($sformatf("rnd%0d_reset_err", t), {31'd0, bus_err}, 32'd0);
                continue;
            end
            if (op == 18) begin
                int w;
                w = $urandom_range(0, DEPTH - 1);
                m_mem[w] = d;
                load(w, d);
                continue;
            end
            if (op <= 2) a = $urandom();
            else         a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            rd = (op == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            wr = (op == 0) ? 1'b1 : !rd;
            off = a - BASE;
            ok  = (a % 4 == 0) && (off / 4 < DEPTH);
            xfer(rd, wr, a, d, be, -1, 0, 32'h0, rdata, lat);
            if (rd && wr) begin
                m_err = 1;
                m_rd  = 32'h0;
                chk($sformatf("rnd%0d_both_lat", t), lat, 1);
            end else begin
                chk($sformatf("rnd%0d_lat", t), lat, LAT);
                if (!ok) m_err = 1;
                if (rd) begin
                    m_rd = ok ? m_mem[off / 4] : 32'h0;
                end else if (ok) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_mem[off / 4][8*b +: 8] = d[8*b +: 8];
                end
            end
            chk($sformatf("rnd%0d_readdata", t), rdata, m_rd);
            chk($sformatf("rnd%0d_bus_err", t), {31'd0, bus_err}, {31'd0, m_err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
